// File: rtl/mips_pkg.sv
// Shared encodings for the memory address selector: FSM states, exception
// cause codes, normal-mode select codes and the request priority encoder.
package mips_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE   = 2'd0,
      CAUSE_OPCODE = 2'd1,
      CAUSE_OVF    = 2'd2,
      CAUSE_DIV0   = 2'd3
   } cause_t;

   localparam logic [2:0] SEL_PC   = 3'b000;
   localparam logic [2:0] SEL_ALU  = 3'b001;
   localparam logic [2:0] SEL_VEC0 = 3'b010;
   localparam logic [2:0] SEL_VEC1 = 3'b011;
   localparam logic [2:0] SEL_VEC2 = 3'b100;

   // Wide enough for the longest supported memory latency (15 cycles).
   localparam int CNT_W = 4;

   // Lowest request bit wins: invalid opcode > overflow > divide-by-zero.
   function automatic cause_t prio_cause(input logic [2:0] req);
      if (req[0])      return CAUSE_OPCODE;
      else if (req[1]) return CAUSE_OVF;
      else if (req[2]) return CAUSE_DIV0;
      else             return CAUSE_NONE;
   endfunction

endpackage

// File: rtl/lat_counter.sv
// Memory wait counter: loads the read latency, counts down while enabled and
// flags the final cycle of the wait.
module lat_counter
   import mips_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_last
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   assign o_last = (r_count == CNT_W'(1));

endmodule

// File: rtl/mem_addr_sel.sv
// Memory address source selector with an exception-vector fetch sequencer
// that overrides the normal select path until the vector byte is read.
module mem_addr_sel
   import mips_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int VEC_BASE = 253,
   parameter int MEM_LAT  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       select,
   input  logic [WIDTH-1:0] in_pc,
   input  logic [WIDTH-1:0] in_alu,
   input  logic [2:0]       exc_req,
   output logic [WIDTH-1:0] addr_out,
   output logic             exc_busy,
   output logic             exc_done,
   output logic [1:0]       exc_cause
);

   localparam logic [WIDTH-1:0] VEC_BASE_W = WIDTH'(VEC_BASE);

   // Vector byte for a cause; wraps modulo 2^WIDTH by construction.
   function automatic logic [WIDTH-1:0] vec_addr(input logic [1:0] cause);
      return VEC_BASE_W + WIDTH'(cause) - WIDTH'(1);
   endfunction

   state_t           r_state;
   cause_t           r_cause;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_vec;

   logic             w_accept;
   logic             w_dec;
   logic             w_last;
   cause_t           w_cause;
   logic [WIDTH-1:0] w_addr;

   assign w_accept = (r_state == ST_IDLE) && (exc_req != 3'b000);
   assign w_dec    = (r_state == ST_FETCH);
   assign w_cause  = prio_cause(exc_req);

   lat_counter u_lat_counter (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_accept),
      .i_load_val (CNT_W'(MEM_LAT)),
      .i_dec      (w_dec),
      .o_last     (w_last)
   );

   always_ff @(posedge clk) begin
      // The vector register only feeds addr_out outside IDLE, so it needs no reset.
      if (w_accept) begin
         r_vec <= vec_addr(w_cause);
      end
      if (reset) begin
         r_state <= ST_IDLE;
         r_cause <= CAUSE_NONE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state <= ST_FETCH;
                  r_cause <= w_cause;
                  r_busy  <= 1'b1;
               end
            end
            ST_FETCH: begin
               if (w_last) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      w_addr = '0;
      if (r_state != ST_IDLE) begin
         w_addr = r_vec;
      end else begin
         case (select)
            SEL_PC:   w_addr = in_pc;
            SEL_ALU:  w_addr = in_alu;
            SEL_VEC0: w_addr = VEC_BASE_W;
            SEL_VEC1: w_addr = VEC_BASE_W + WIDTH'(1);
            SEL_VEC2: w_addr = VEC_BASE_W + WIDTH'(2);
            default:  w_addr = '0;
         endcase
      end
   end

   assign addr_out  = w_addr;
   assign exc_busy  = r_busy;
   assign exc_done  = r_done;
   assign exc_cause = r_cause;

endmodule

// File: tb/tb_mem_addr_sel.sv
// Scoreboard bench for mem_addr_sel: two instances (MEM_LAT 1 and 3) share
// stimulus; a reference model queues expected outputs for every cycle.
module tb_mem_addr_sel;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  select;
   logic [31:0] in_pc;
   logic [31:0] in_alu;
   logic [2:0]  exc_req;

   logic [31:0] addr1, addr3;
   logic        busy1, busy3, done1, done3;
   logic [1:0]  cause1, cause3;

   always #5 clk = ~clk;

   mem_addr_sel #(.WIDTH(32), .VEC_BASE(253), .MEM_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .select(select), .in_pc(in_pc), .in_alu(in_alu),
      .exc_req(exc_req), .addr_out(addr1), .exc_busy(busy1), .exc_done(done1),
      .exc_cause(cause1)
   );

   mem_addr_sel #(.WIDTH(32), .VEC_BASE(253), .MEM_LAT(3)) dut3 (
      .clk(clk), .reset(reset), .select(select), .in_pc(in_pc), .in_alu(in_alu),
      .exc_req(exc_req), .addr_out(addr3), .exc_busy(busy3), .exc_done(done3),
      .exc_cause(cause3)
   );

   typedef struct {
      logic [31:0] addr;
      logic        busy;
      logic        done;
      logic [1:0]  cause;
   } exp_t;

   exp_t        q[$];
   int          n_checks = 0;
   int          n_errors = 0;

   // Reference model per instance: state 0 idle, 1 fetch, 2 done.
   int          m_state[2];
   int          m_cnt[2];
   int          m_cause[2];
   logic [31:0] m_vec[2];
   int          lat[2] = '{1, 3};
   int          cyc = 0;
   int          done_cyc[2];
   int          req_cyc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step(input logic [2:0] sel, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [2:0] req, input logic rst);
      exp_t e;
      int   c;
      select  = sel;
      in_pc   = pc;
      in_alu  = alu;
      exc_req = req;
      reset   = rst;
      for (int i = 0; i < 2; i++) begin
         e.busy  = (m_state[i] != 0);
         e.done  = (m_state[i] == 2);
         e.cause = 2'(m_cause[i]);
         if (m_state[i] != 0) e.addr = m_vec[i];
         else begin
            case (sel)
               3'd0:    e.addr = pc;
               3'd1:    e.addr = alu;
               3'd2:    e.addr = 32'd253;
               3'd3:    e.addr = 32'd254;
               3'd4:    e.addr = 32'd255;
               default: e.addr = 32'd0;
            endcase
         end
         q.push_back(e);
      end
      @(negedge clk);
      e = q.pop_front();
      check("addr1", addr1, e.addr);
      check("busy1", 32'(busy1), 32'(e.busy));
      check("done1", 32'(done1), 32'(e.done));
      check("cause1", 32'(cause1), 32'(e.cause));
      e = q.pop_front();
      check("addr3", addr3, e.addr);
      check("busy3", 32'(busy3), 32'(e.busy));
      check("done3", 32'(done3), 32'(e.done));
      check("cause3", 32'(cause3), 32'(e.cause));
      if (done1 === 1'b1 && done_cyc[0] < 0) done_cyc[0] = cyc;
      if (done3 === 1'b1 && done_cyc[1] < 0) done_cyc[1] = cyc;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_state[i] = 0; m_cnt[i] = 0; m_cause[i] = 0;
         end else begin
            case (m_state[i])
               0: if (req != 3'b000) begin
                     c = req[0] ? 1 : (req[1] ? 2 : 3);
                     m_cause[i] = c;
                     m_vec[i]   = 32'd253 + 32'(c) - 32'd1;
                     m_cnt[i]   = lat[i];
                     m_state[i] = 1;
                  end
               1: begin
                     if (m_cnt[i] == 1) m_state[i] = 2;
                     m_cnt[i] = m_cnt[i] - 1;
                  end
               default: m_state[i] = 0;
            endcase
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n, input logic [2:0] sel);
      for (int k = 0; k < n; k++) step(sel, 32'h40, 32'h1234, 3'b000, 1'b0);
   endtask

   task automatic arm();
      done_cyc[0] = -1;
      done_cyc[1] = -1;
      req_cyc     = cyc;
   endtask

   initial begin
      reset = 1'b1; select = 3'd0; in_pc = '0; in_alu = '0; exc_req = '0;
      for (int i = 0; i < 2; i++) begin
         m_state[i] = 0; m_cnt[i] = 0; m_cause[i] = 0; m_vec[i] = '0;
      end
      repeat (2) @(posedge clk);
      #1;

      // Reset held: outputs follow select, no exception activity.
      step(3'd2, 32'h0, 32'h0, 3'b111, 1'b1);
      // Plain address selection.
      step(3'd0, 32'h40, 32'h1234, 3'b000, 1'b0);
      step(3'd1, 32'h40, 32'h1234, 3'b000, 1'b0);
      for (int s = 0; s < 8; s++) step(3'(s), 32'hCAFE_0000 + 32'(s), 32'h0BAD_0000 + 32'(s), 3'b000, 1'b0);

      // Overflow exception: vector 254, cause 2.
      arm();
      step(3'd0, 32'h40, 32'h1234, 3'b010, 1'b0);
      idle(5, 3'd1);
      check("cause_ovf", 32'(cause1), 32'd2);
      check("lat_ovf_1", 32'(done_cyc[0] - req_cyc), 32'd2);

      // Opcode exception on MEM_LAT=3: done four cycles after the sampling edge.
      arm();
      step(3'd5, 32'h40, 32'h1234, 3'b001, 1'b0);
      idle(6, 3'd5);
      check("lat_opc_3", 32'(done_cyc[1] - req_cyc), 32'd4);
      check("lat_opc_1", 32'(done_cyc[0] - req_cyc), 32'd2);

      // All requests at once: opcode wins.
      step(3'd0, 32'h40, 32'h1234, 3'b111, 1'b0);
      idle(6, 3'd0);
      check("cause_prio", 32'(cause3), 32'd1);

      // Divide-by-zero raised while busy is ignored.
      arm();
      step(3'd0, 32'h40, 32'h1234, 3'b001, 1'b0);
      step(3'd0, 32'h40, 32'h1234, 3'b100, 1'b0);
      step(3'd0, 32'h40, 32'h1234, 3'b100, 1'b0);
      idle(5, 3'd0);
      check("ign_cause", 32'(cause1), 32'd1);
      check("ign_lat_3", 32'(done_cyc[1] - req_cyc), 32'd4);

      // Reset in the middle of a fetch.
      step(3'd0, 32'h40, 32'h1234, 3'b010, 1'b0);
      step(3'd1, 32'h40, 32'h1234, 3'b000, 1'b1);
      step(3'd1, 32'h40, 32'h1234, 3'b000, 1'b0);
      idle(2, 3'd0);

      // Randomised traffic.
      for (int k = 0; k < 400; k++) begin
         step(3'($urandom_range(0, 7)), $urandom, $urandom,
              ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
              ($urandom_range(0, 29) == 0));
      end

      check("queue_empty", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_addr_sel.md
MEM_ADDR_SEL -- requirements
Module: mem_addr_sel

Interface
REQ-001 SHALL have parameter WIDTH, default 32, address width in bits.
REQ-002 SHALL have parameter VEC_BASE, default 253, address of the first exception vector byte.
REQ-003 SHALL have parameter MEM_LAT, default 1, memory read latency in cycles (1..15).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port select  input  3  normal-mode source select.
REQ-007 SHALL have port in_pc  input  WIDTH  PC address.
REQ-008 SHALL have port in_alu  input  WIDTH  ALUOut address.
REQ-009 SHALL have port exc_req  input  3  exception requests: bit0 invalid opcode, bit1 overflow, bit2 divide-by-zero.
REQ-010 SHALL have port addr_out  output  WIDTH  memory address.
REQ-011 SHALL have port exc_busy  output  1  high while a vector fetch is in progress.
REQ-012 SHALL have port exc_done  output  1  one-cycle pulse when the vector byte is valid on memory data-out.
REQ-013 SHALL have port exc_cause  output  2  last accepted cause: 0 none, 1 opcode, 2 overflow, 3 div0.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, DONE.
REQ-015 In IDLE, addr_out SHALL be combinational from select: 000 in_pc, 001 in_alu, 010 VEC_BASE, 011 VEC_BASE+1, 100 VEC_BASE+2, 101/110/111 zero.
REQ-016 In IDLE, any exc_req bit high SHALL transition to FETCH on the next edge, latching the cause and loading the wait counter with MEM_LAT.
REQ-017 Simultaneous exc_req bits SHALL resolve by priority bit0 > bit1 > bit2.
REQ-018 Vector address SHALL be VEC_BASE + (cause-1), zero-extended to WIDTH.
REQ-019 In FETCH and DONE, addr_out SHALL equal the latched vector address, ignoring select.
REQ-020 In FETCH, the counter SHALL decrement once per cycle; at count 1 the FSM SHALL go to DONE on the next edge.
REQ-021 DONE SHALL last exactly one cycle, assert exc_done, then return to IDLE.
REQ-022 exc_busy SHALL be high in FETCH and DONE, low in IDLE.
REQ-023 exc_req SHALL be ignored while exc_busy is high; no queuing.
REQ-024 Total latency from the exc_req sampling edge to exc_done high SHALL be MEM_LAT+1 cycles.
REQ-025 exc_cause SHALL hold its value after DONE until the next accepted exception or reset.
REQ-026 Vector arithmetic SHALL be modulo 2^WIDTH; no saturation.

Reset
REQ-027 Reset SHALL force state IDLE, counter 0, exc_cause 0, exc_busy 0, exc_done 0.
REQ-028 Reset SHALL take priority over all other events, including in the same cycle as exc_req or in mid-FETCH.
REQ-029 After reset, addr_out SHALL follow REQ-015 from the first cycle.

Structure
REQ-030 State encodings, cause codes, and select codes SHALL live in a shared package mips_pkg.
REQ-031 The wait counter SHALL be a sub-module lat_counter (load, decrement, last-count flag).
REQ-032 All sequential logic SHALL use a single clocked process on clk with synchronous reset.

Verification
REQ-033 select=000 with in_pc=0x40, then select=001 with in_alu=0x1234 -> addr_out 0x40, then 0x1234, with exc_busy 0.
REQ-034 exc_req=010 with MEM_LAT=1 -> addr_out 254 for 2 cycles, exc_done high on the 2nd cycle, exc_cause=2, then IDLE.
REQ-035 exc_req=111 -> cause 1 and addr_out 253.
REQ-036 exc_req=100 mid-FETCH of cause 1 -> ignored; exc_cause stays 1 and timing is unchanged.
REQ-037 Reset asserted during FETCH -> next cycle IDLE, exc_busy 0, exc_cause 0, addr_out follows select.
REQ-038 MEM_LAT=3 with exc_req=001 -> exc_done exactly 4 cycles after the sampling edge, and addr_out 253 throughout.
